// File: rtl/alu_sequencer.sv
// alu_sequencer: command sequencer in front of an external 8-bit ALU.
// It holds the accumulator (A) and operand (B) registers, drives the ALU bus-drive
// strobes for one EXEC cycle and returns the captured result over a valid/ready handshake.
// Optional feature: define ALU_SEQ_CMP_EN to enable the CMP opcode (3'b100);
// without it, CMP is handled as an illegal opcode.
module alu_sequencer (
  input  logic       clk,
  input  logic       resetBar,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic [2:0] cmdOp,
  input  logic [7:0] cmdImm,
  output logic [7:0] areg,
  output logic [7:0] breg,
  output logic       doSubtract,
  output logic       assertBarE,
  output logic       assertBarS,
  input  logic [7:0] dbus,
  input  logic       flagCarry,
  input  logic       flagShift,
  output logic       resValid,
  input  logic       resReady,
  output logic [7:0] resData,
  output logic       resCarry,
  output logic       resZero,
  output logic       resErr,
  output logic       busy
);

  localparam logic [2:0] OpLda = 3'b000;
  localparam logic [2:0] OpAdd = 3'b001;
  localparam logic [2:0] OpSub = 3'b010;
  localparam logic [2:0] OpShr = 3'b011;
  localparam logic [2:0] OpCmp = 3'b100;

`ifdef ALU_SEQ_CMP_EN
  localparam logic CmpEn = 1'b1;
`else
  localparam logic CmpEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StSetup, StExec, StDone} state_e;

  state_e     r_state;
  state_e     w_state_next;
  logic [2:0] r_op;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_res_data;
  logic       r_res_carry;
  logic       r_res_zero;
  logic       r_res_err;
  logic       r_ready_en;  // keeps cmdReady low until the first edge after reset

  logic w_accept;
  logic w_cmd_alu;
  logic w_op_arith;
  logic w_op_shr;
  logic w_op_sub;
  logic w_op_wb;

  assign w_accept   = cmdValid && cmdReady;
  assign w_cmd_alu  = (cmdOp == OpAdd) || (cmdOp == OpSub) || (cmdOp == OpShr) ||
                      (CmpEn && (cmdOp == OpCmp));
  // r_op only ever holds a legal ALU op, so CMP appears here only when enabled
  assign w_op_arith = (r_op == OpAdd) || (r_op == OpSub) || (r_op == OpCmp);
  assign w_op_shr   = (r_op == OpShr);
  assign w_op_sub   = (r_op == OpSub) || (r_op == OpCmp);
  assign w_op_wb    = (r_op == OpAdd) || (r_op == OpSub) || (r_op == OpShr);

  // State register
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) r_state <= StIdle;
    else           r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = w_cmd_alu ? StSetup : StDone;
      StSetup: w_state_next = StExec;
      StExec:  w_state_next = StDone;
      StDone:  if (resReady) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs decoded from state; strobes can only go low in EXEC, and never together
  always_comb begin
    cmdReady   = (r_state == StIdle) && r_ready_en;
    busy       = (r_state != StIdle);
    resValid   = (r_state == StDone);
    doSubtract = ((r_state == StSetup) || (r_state == StExec)) && w_op_sub;
    assertBarE = !((r_state == StExec) && w_op_arith);
    assertBarS = !((r_state == StExec) && w_op_shr);
  end

  // Datapath: command latch, A/B registers and result capture
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      r_ready_en  <= 1'b0;
      r_op        <= OpLda;
      r_a         <= 8'h00;
      r_b         <= 8'h00;
      r_res_data  <= 8'h00;
      r_res_carry <= 1'b0;
      r_res_zero  <= 1'b0;
      r_res_err   <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_accept) begin
        if (cmdOp == OpLda) begin
          r_a         <= cmdImm;
          r_res_data  <= cmdImm;
          r_res_carry <= 1'b0;
          r_res_zero  <= (cmdImm == 8'h00);
          r_res_err   <= 1'b0;
        end else if (w_cmd_alu) begin
          r_op <= cmdOp;
          if (cmdOp != OpShr) r_b <= cmdImm;
        end else begin
          // illegal opcode: report current A, leave A/B alone
          r_res_data  <= r_a;
          r_res_carry <= 1'b0;
          r_res_zero  <= (r_a == 8'h00);
          r_res_err   <= 1'b1;
        end
      end else if (r_state == StExec) begin
        r_res_data  <= dbus;
        r_res_zero  <= (dbus == 8'h00);
        r_res_carry <= w_op_shr ? flagShift : flagCarry;
        r_res_err   <= 1'b0;
        if (w_op_wb) r_a <= dbus;
      end
    end
  end

  assign areg     = r_a;
  assign breg     = r_b;
  assign resData  = r_res_data;
  assign resCarry = r_res_carry;
  assign resZero  = r_res_zero;
  assign resErr   = r_res_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed commands, an external ALU model on dbus and a
// result scoreboard popped by a monitor whenever a result handshake completes.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       resetBar;
  logic       cmdValid;
  logic       cmdReady;
  logic [2:0] cmdOp;
  logic [7:0] cmdImm;
  logic [7:0] areg;
  logic [7:0] breg;
  logic       doSubtract;
  logic       assertBarE;
  logic       assertBarS;
  logic [7:0] dbus;
  logic       flagCarry;
  logic       flagShift;
  logic       resValid;
  logic       resReady;
  logic [7:0] resData;
  logic       resCarry;
  logic       resZero;
  logic       resErr;
  logic       busy;

  logic tb_shift_flag;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk        (clk),
    .resetBar   (resetBar),
    .cmdValid   (cmdValid),
    .cmdReady   (cmdReady),
    .cmdOp      (cmdOp),
    .cmdImm     (cmdImm),
    .areg       (areg),
    .breg       (breg),
    .doSubtract (doSubtract),
    .assertBarE (assertBarE),
    .assertBarS (assertBarS),
    .dbus       (dbus),
    .flagCarry  (flagCarry),
    .flagShift  (flagShift),
    .resValid   (resValid),
    .resReady   (resReady),
    .resData    (resData),
    .resCarry   (resCarry),
    .resZero    (resZero),
    .resErr     (resErr),
    .busy       (busy)
  );

  // External ALU: drives dbus only while a strobe is low, otherwise a junk value
  always_comb begin
    dbus      = 8'hEE;
    flagCarry = 1'b0;
    if (!assertBarE) begin
      if (doSubtract) {flagCarry, dbus} = {1'b0, areg} + {1'b0, ~breg} + 9'd1;
      else            {flagCarry, dbus} = {1'b0, areg} + {1'b0, breg};
    end else if (!assertBarS) begin
      dbus = {1'b0, areg[7:1]};
    end
  end
  assign flagShift = tb_shift_flag;

  typedef struct packed {
    logic [7:0] data;
    logic       carry;
    logic       zero;
    logic       err;
  } res_t;

  res_t exp_q[$];
  res_t mon_e;
  int   errors = 0;
  int   checks = 0;

  function automatic res_t mk(input logic [7:0] d, input logic c, input logic z,
                              input logic e);
    res_t r;
    r.data  = d;
    r.carry = c;
    r.zero  = z;
    r.err   = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (resetBar && resValid && resReady) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resData",  {24'd0, resData}, {24'd0, mon_e.data});
        chk("resCarry", {31'd0, resCarry}, {31'd0, mon_e.carry});
        chk("resZero",  {31'd0, resZero}, {31'd0, mon_e.zero});
        chk("resErr",   {31'd0, resErr}, {31'd0, mon_e.err});
      end
    end
  end

  // Wait (bounded) for cmdReady at a falling edge, then present one command for one edge
  task automatic issue(input string nm, input logic [2:0] op, input logic [7:0] imm);
    int budget;
    @(negedge clk);
    budget = 0;
    while (!cmdReady && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk({nm, "_ready"}, {31'd0, cmdReady}, 32'd1);
    cmdOp    = op;
    cmdImm   = imm;
    cmdValid = 1'b1;
    @(posedge clk);
    #1;
    cmdValid = 1'b0;
    cmdImm   = 8'hC3;
  endtask

  task automatic do_op(input string nm, input logic [2:0] op, input logic [7:0] imm,
                       input res_t exp, input int exp_lat, input int exp_e,
                       input int exp_s, input int exp_ds, input logic [7:0] exp_a);
    int lat;
    int ne;
    int ns;
    int nds;
    exp_q.push_back(exp);
    issue(nm, op, imm);
    lat = 0;
    ne  = 0;
    ns  = 0;
    nds = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!assertBarE) ne++;
      if (!assertBarS) ns++;
      if (doSubtract)  nds++;
      chk({nm, "_strobe_excl"}, {31'd0, assertBarE | assertBarS}, 32'd1);
    end while (!resValid && lat < 10);
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_strobeE_cycles"}, ne, exp_e);
    chk({nm, "_strobeS_cycles"}, ns, exp_s);
    chk({nm, "_doSub_cycles"}, nds, exp_ds);
    @(negedge clk);
    chk({nm, "_idle"}, {31'd0, busy}, 32'd0);
    chk({nm, "_areg"}, {24'd0, areg}, {24'd0, exp_a});
  endtask

  logic [7:0] held_data;
  int         vcnt;
  int         budget;

  initial begin
    resetBar      = 1'b1;
    cmdValid      = 1'b0;
    cmdOp         = 3'b000;
    cmdImm        = 8'h00;
    resReady      = 1'b1;
    tb_shift_flag = 1'b0;
    #2 resetBar = 1'b0;
    #1;
    chk("rst_cmdReady", {31'd0, cmdReady}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_areg", {24'd0, areg}, 32'd0);
    chk("rst_breg", {24'd0, breg}, 32'd0);
    chk("rst_strobes", {30'd0, assertBarE, assertBarS}, 32'd3);
    chk("rst_valid_dosub", {30'd0, resValid, doSubtract}, 32'd0);
    chk("rst_res", {21'd0, resData, resCarry, resZero, resErr}, 32'd0);
    repeat (2) @(negedge clk);
    resetBar = 1'b1;
    #1 chk("rel_cmdReady_low", {31'd0, cmdReady}, 32'd0);
    @(negedge clk);
    chk("rel_cmdReady_high", {31'd0, cmdReady}, 32'd1);

    do_op("lda05", 3'b000, 8'h05, mk(8'h05, 1'b0, 1'b0, 1'b0), 1, 0, 0, 0, 8'h05);
    do_op("add03", 3'b001, 8'h03, mk(8'h08, 1'b0, 1'b0, 1'b0), 3, 1, 0, 0, 8'h08);
    chk("add03_breg", {24'd0, breg}, 32'h03);
    do_op("lda05b", 3'b000, 8'h05, mk(8'h05, 1'b0, 1'b0, 1'b0), 1, 0, 0, 0, 8'h05);
    do_op("sub05", 3'b010, 8'h05, mk(8'h00, 1'b1, 1'b1, 1'b0), 3, 1, 0, 2, 8'h00);
    do_op("lda81", 3'b000, 8'h81, mk(8'h81, 1'b0, 1'b0, 1'b0), 1, 0, 0, 0, 8'h81);
    tb_shift_flag = 1'b0;
    do_op("shr_f0", 3'b011, 8'hAA, mk(8'h40, 1'b0, 1'b0, 1'b0), 3, 0, 1, 0, 8'h40);
    tb_shift_flag = 1'b1;
    do_op("shr_f1", 3'b011, 8'h77, mk(8'h20, 1'b1, 1'b0, 1'b0), 3, 0, 1, 0, 8'h20);
    tb_shift_flag = 1'b0;
    do_op("lda10", 3'b000, 8'h10, mk(8'h10, 1'b0, 1'b0, 1'b0), 1, 0, 0, 0, 8'h10);
`ifdef ALU_SEQ_CMP_EN
    do_op("cmp20", 3'b100, 8'h20, mk(8'hF0, 1'b0, 1'b0, 1'b0), 3, 1, 0, 2, 8'h10);
`else
    do_op("cmp20", 3'b100, 8'h20, mk(8'h10, 1'b0, 1'b0, 1'b1), 1, 0, 0, 0, 8'h10);
`endif
    do_op("illegal", 3'b111, 8'h55, mk(8'h10, 1'b0, 1'b0, 1'b1), 1, 0, 0, 0, 8'h10);
`ifdef ALU_SEQ_CMP_EN
    chk("illegal_breg", {24'd0, breg}, 32'h20);
`else
    chk("illegal_breg", {24'd0, breg}, 32'h05);
`endif
    do_op("addFF_wrap", 3'b001, 8'hFF, mk(8'h0F, 1'b1, 1'b0, 1'b0), 3, 1, 0, 0, 8'h0F);

    // Result stall: resReady low for 5 DONE cycles while a new command is offered
    exp_q.push_back(mk(8'h00, 1'b0, 1'b1, 1'b0));
    resReady = 1'b0;
    issue("stall_lda00", 3'b000, 8'h00);
    budget = 0;
    @(negedge clk);
    while (!resValid && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    chk("stall_valid_seen", {31'd0, resValid}, 32'd1);
    held_data = resData;
    cmdOp     = 3'b000;
    cmdImm    = 8'hAA;
    cmdValid  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, resValid}, 32'd1);
      chk("stall_data", {24'd0, resData}, {24'd0, held_data});
      chk("stall_zero", {31'd0, resZero}, 32'd1);
      chk("stall_cmdReady", {31'd0, cmdReady}, 32'd0);
    end
    cmdValid = 1'b0;
    @(posedge clk);
    #1 resReady = 1'b1;
    repeat (2) @(negedge clk);
    chk("stall_areg", {24'd0, areg}, 32'h00);
    chk("stall_idle", {31'd0, busy}, 32'd0);

    // Reset during EXEC aborts the ADD with no result and clears A
    do_op("lda33", 3'b000, 8'h33, mk(8'h33, 1'b0, 1'b0, 1'b0), 1, 0, 0, 0, 8'h33);
    issue("abort_add", 3'b001, 8'h01);
    repeat (2) @(negedge clk);
    chk("abort_exec_strobeE", {31'd0, assertBarE}, 32'd0);
    #1 resetBar = 1'b0;
    #1;
    chk("abort_strobes", {30'd0, assertBarE, assertBarS}, 32'd3);
    chk("abort_areg", {24'd0, areg}, 32'd0);
    chk("abort_busy_ready", {30'd0, busy, cmdReady}, 32'd0);
    chk("abort_valid", {31'd0, resValid}, 32'd0);
    @(negedge clk);
    resetBar = 1'b1;
    vcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (resValid) vcnt++;
    end
    chk("abort_no_result", vcnt, 0);
    chk("abort_areg_after", {24'd0, areg}, 32'd0);
    chk("abort_cmdReady", {31'd0, cmdReady}, 32'd1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
